// File: rtl/cp0_timer_intc_if.sv
// mtc0/mfc0 access bus shared between the CP0 register file (master) and the
// Count/Compare timer block (slave). Addresses are {rd[4:0], sel[2:0]}.
interface cp0_timer_intc_if;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/cp0_timer_intc.sv
// CP0 Count/Compare timer and interrupt controller with synchronised external lines.
// Optional CP0_TIMER_GATE_EN adds a count_stop input that freezes the prescaler and Count.
module cp0_timer_intc #(
    parameter int unsigned NUM_CMP     = 1,
    parameter int unsigned CNT_DIV     = 2,
    parameter int unsigned EXT_INT_W   = 6,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
`ifdef CP0_TIMER_GATE_EN
    input  logic                 count_stop,
`endif
    cp0_timer_intc_if.slave      bus,
    input  logic [EXT_INT_W-1:0] ext_int,
    input  logic [1:0]           sw_ip,
    input  logic                 status_ie,
    input  logic                 status_exl,
    input  logic                 status_erl,
    input  logic [7:0]           status_im,
    output logic [7:0]           cause_ip,
    output logic                 cause_ti,
    output logic [NUM_CMP-1:0]   ti_vec,
    output logic                 int_req,
    output logic [31:0]          count_out
);

    localparam logic [7:0] ADDR_COUNT = {5'd9, 3'd0};
    localparam logic [7:0] ADDR_CMP   = {5'd11, 3'd0};
    localparam logic [7:0] ADDR_CAUSE = {5'd13, 3'd0};
    localparam logic [3:0] DIV_LAST   = 4'(CNT_DIV - 1);

    logic                 stop;
    logic [3:0]           presc_q;
    logic [31:0]          count_q;
    logic [31:0]          cmp_q [NUM_CMP];
    logic [NUM_CMP-1:0]   ti_q;
    logic [NUM_CMP-1:0]   ti_d;
    logic [NUM_CMP-1:0]   cmp_wr;
    logic                 count_wr;
    logic                 tick;
    logic [EXT_INT_W-1:0] sync_q [SYNC_STAGES];
    logic [5:0]           ext_full;
    logic [5:0]           ip_q;
    logic [5:0]           ip_d;

`ifdef CP0_TIMER_GATE_EN
    assign stop = count_stop;
`else
    assign stop = 1'b0;
`endif

    assign count_wr = bus.wr_en && (bus.wr_addr == ADDR_COUNT);
    assign tick     = !stop && (presc_q == DIV_LAST);

    // Clear-on-write beats a same-cycle match so software never sees a stale TI.
    always_comb begin
        cmp_wr = '0;
        ti_d   = '0;
        for (int unsigned k = 0; k < NUM_CMP; k++) begin
            cmp_wr[k] = bus.wr_en && (bus.wr_addr == (ADDR_CMP | 8'(k)));
            ti_d[k]   = cmp_wr[k] ? 1'b0 : (ti_q[k] | (count_q == cmp_q[k]));
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc_q <= '0;
            count_q <= '0;
            ti_q    <= '0;
            for (int unsigned k = 0; k < NUM_CMP; k++) begin
                cmp_q[k] <= '1;
            end
        end else begin
            if (count_wr) begin
                presc_q <= '0;
                count_q <= bus.wr_data;
            end else if (!stop) begin
                presc_q <= tick ? 4'd0 : presc_q + 4'd1;
                if (tick) begin
                    count_q <= count_q + 32'd1;
                end
            end
            for (int unsigned k = 0; k < NUM_CMP; k++) begin
                if (cmp_wr[k]) begin
                    cmp_q[k] <= bus.wr_data;
                end
            end
            ti_q <= ti_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            ip_q <= '0;
        end else begin
            sync_q[0] <= ext_int;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            ip_q <= ip_d;
        end
    end

    // Lines above EXT_INT_W read as 0; IP7 also carries the timer interrupt.
    always_comb begin
        ext_full = 6'(sync_q[SYNC_STAGES-1]);
        ip_d     = {ext_full[5] | cause_ti, ext_full[4:0]};
    end

    assign cause_ti  = |ti_q;
    assign ti_vec    = ti_q;
    assign cause_ip  = {ip_q, sw_ip};
    assign count_out = count_q;
    assign int_req   = status_ie & ~status_exl & ~status_erl & (|(cause_ip & status_im));

    always_comb begin
        bus.rd_data = '0;
        if (bus.rd_addr == ADDR_COUNT) begin
            bus.rd_data = count_q;
        end
        if (bus.rd_addr == ADDR_CAUSE) begin
            bus.rd_data = {cause_ti, 1'b0, 14'b0, cause_ip, 8'b0};
        end
        for (int unsigned k = 0; k < NUM_CMP; k++) begin
            if (bus.rd_addr == (ADDR_CMP | 8'(k))) begin
                bus.rd_data = cmp_q[k];
            end
        end
    end

endmodule

// File: tb/tb_cp0_timer_intc.sv
// Directed bench for cp0_timer_intc with NUM_CMP=2, CNT_DIV=2, SYNC_STAGES=2.
module tb_cp0_timer_intc;

    logic        clk = 1'b0;
    logic        resetn;
    logic [5:0]  ext_int;
    logic [1:0]  sw_ip;
    logic        status_ie, status_exl, status_erl;
    logic [7:0]  status_im;
    logic [7:0]  cause_ip;
    logic        cause_ti;
    logic [1:0]  ti_vec;
    logic        int_req;
    logic [31:0] count_out;
`ifdef CP0_TIMER_GATE_EN
    logic        count_stop;
`endif

    int n_checks = 0;
    int n_errors = 0;

    cp0_timer_intc_if bus ();

    cp0_timer_intc #(
        .NUM_CMP     (2),
        .CNT_DIV     (2),
        .EXT_INT_W   (6),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
`ifdef CP0_TIMER_GATE_EN
        .count_stop (count_stop),
`endif
        .bus        (bus),
        .ext_int    (ext_int),
        .sw_ip      (sw_ip),
        .status_ie  (status_ie),
        .status_exl (status_exl),
        .status_erl (status_erl),
        .status_im  (status_im),
        .cause_ip   (cause_ip),
        .cause_ti   (cause_ti),
        .ti_vec     (ti_vec),
        .int_req    (int_req),
        .count_out  (count_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        bus.rd_addr = addr;
        #1;
        check(tag, bus.rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetn      = 1'b0;
        ext_int     = '0;
        sw_ip       = '0;
        status_ie   = 1'b0;
        status_exl  = 1'b0;
        status_erl  = 1'b0;
        status_im   = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.rd_addr = '0;
`ifdef CP0_TIMER_GATE_EN
        count_stop  = 1'b0;
`endif
        tick();
        tick();

        // Reset state
        check("rst_count", count_out, 32'd0);
        check("rst_cause_ip", 32'(cause_ip), 32'd0);
        check("rst_ti", 32'(ti_vec), 32'd0);
        check("rst_int_req", 32'(int_req), 32'd0);
        rd_chk("rst_cmp0", 8'h58, 32'hFFFF_FFFF);
        rd_chk("rst_cmp1", 8'h59, 32'hFFFF_FFFF);
        rd_chk("rst_cause_rd", 8'h68, 32'd0);

        // Free-running count with CNT_DIV=2
        resetn = 1'b1;
        tick(); check("cnt_seq0", count_out, 32'd0);
        tick(); check("cnt_seq1", count_out, 32'd1);
        tick(); check("cnt_seq2", count_out, 32'd1);
        tick(); check("cnt_seq3", count_out, 32'd2);
        rd_chk("cnt_rd", 8'h48, 32'd2);

        // Compare0 match drives TI, IP7 and int_req
        status_ie = 1'b1;
        status_im = 8'h80;
        wr(8'h48, 32'd5);
        wr(8'h58, 32'd8);
        check("cnt_loaded", count_out, 32'd5);
        repeat (4) tick();
        tick();
        check("cnt_at8", count_out, 32'd8);
        check("ti_before", 32'(ti_vec), 32'd0);
        tick();
        check("ti0_set", 32'(ti_vec), 32'd1);
        check("irq_lag", 32'(int_req), 32'd0);
        tick();
        check("irq_set", 32'(int_req), 32'd1);
        check("ip7_set", 32'(cause_ip), 32'h80);
        rd_chk("cause_rd", 8'h68, 32'h8000_8000);
        wr(8'h58, 32'd20);
        check("ti0_clr", 32'(ti_vec), 32'd0);
        check("ip7_hold", 32'(cause_ip), 32'h80);
        tick();
        check("ip7_clr", 32'(cause_ip), 32'h00);
        check("irq_clr", 32'(int_req), 32'd0);

        // Two channels: Compare1 fires first, clears independently
        wr(8'h48, 32'd0);
        wr(8'h58, 32'd10);
        wr(8'h59, 32'd6);
        repeat (10) tick();
        check("ti_pre6", 32'(ti_vec), 32'd0);
        tick();
        check("ti1_first", 32'(ti_vec), 32'd2);
        check("cause_ti1", 32'(cause_ti), 32'd1);
        repeat (8) tick();
        check("ti_both", 32'(ti_vec), 32'd3);
        wr(8'h59, 32'd100);
        check("ti1_only_clr", 32'(ti_vec), 32'd1);
        check("cause_ti0", 32'(cause_ti), 32'd1);
        wr(8'h58, 32'hFFFF_FFFF);
        check("ti_none", 32'(ti_vec), 32'd0);
        wr(8'h5A, 32'h1234);
        rd_chk("unmapped_sel2", 8'h5A, 32'd0);
        rd_chk("unmapped_0", 8'h00, 32'd0);
        rd_chk("cmp1_rd", 8'h59, 32'd100);

        // External line latency = SYNC_STAGES+1
        status_im = 8'h10;
        ext_int   = 6'b000100;
        tick();
        ext_int   = '0;
        tick();
        check("ext_lat2", 32'(cause_ip), 32'h00);
        tick();
        check("ext_lat3", 32'(cause_ip), 32'h10);
        check("ext_irq", 32'(int_req), 32'd1);
        status_exl = 1'b1;
        #1;
        check("exl_mask", 32'(int_req), 32'd0);
        tick();
        check("ext_pulse_end", 32'(cause_ip), 32'h00);
        status_exl = 1'b0;
        sw_ip      = 2'b01;
        status_im  = 8'h01;
        #1;
        check("sw_irq", 32'(int_req), 32'd1);
        check("sw_ip_pass", 32'(cause_ip), 32'h01);
        sw_ip     = '0;
        status_im = '0;

        // Same-cycle Compare write and match; same-cycle Count write and increment
        wr(8'h58, 32'd51);
        wr(8'h48, 32'd50);
        tick();
        tick();
        check("cnt51", count_out, 32'd51);
        wr(8'h58, 32'd200);
        check("cmpwr_wins", 32'(ti_vec), 32'd0);
        wr(8'h48, 32'h77);
        check("cntwr_wins", count_out, 32'h77);
        check("cmpwr_wins2", 32'(ti_vec), 32'd0);
        tick();
        check("presc_clr", count_out, 32'h77);
        tick();
        check("cnt_resume", count_out, 32'h78);

        // Reset mid-activity clears everything
        ext_int   = 6'h3F;
        status_im = 8'hFC;
        repeat (3) tick();
        check("ext_all", 32'(cause_ip), 32'hFC);
        check("ext_all_irq", 32'(int_req), 32'd1);
        ext_int = '0;
        resetn  = 1'b0;
        tick();
        check("rst2_cause_ip", 32'(cause_ip), 32'h00);
        check("rst2_irq", 32'(int_req), 32'd0);
        check("rst2_count", count_out, 32'd0);
        rd_chk("rst2_cmp0", 8'h58, 32'hFFFF_FFFF);
        resetn = 1'b1;
        tick();
        check("rst2_sync", 32'(cause_ip), 32'h00);

`ifdef CP0_TIMER_GATE_EN
        count_stop = 1'b1;
        repeat (10) tick();
        check("stop_frozen", count_out, 32'd0);
        wr(8'h48, 32'h100);
        check("stop_wr", count_out, 32'h100);
        tick();
        check("stop_hold", count_out, 32'h100);
        count_stop = 1'b0;
        tick();
        tick();
        check("stop_release", count_out, 32'h101);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
